// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// The cache has one 32-bit word per line and issues one backing-memory transaction at a time.
module dcache_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cpu_req,
  input  logic                           cpu_we,
  input  logic [31:0]                    cpu_addr,
  input  logic [31:0]                    cpu_wdata,
  output logic                           cpu_ready,
  output logic                           cpu_resp,
  output logic [31:0]                    cpu_rdata,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [INDEX_BITS+TAG_BITS-1:0] mem_addr,
  output logic [31:0]                    mem_wdata,
  input  logic                           mem_ack,
  input  logic [31:0]                    mem_rdata,
  output logic [1:0]                     fsm_state
);

  localparam int AW    = INDEX_BITS + TAG_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  // Handshakes: a CPU request is taken on any edge with cpu_req && cpu_ready and
  // answered by exactly one cpu_resp pulse; a memory request (mem_req and its
  // qualifiers) is held unchanged until the edge on which mem_ack is seen.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         data [LINES];

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  unused_addr_bits;

  logic load_hit;
  logic issue_fill;
  logic issue_write;
  logic complete;
  logic fill_done;

  assign req_index        = cpu_addr[INDEX_BITS+1:2];
  assign req_tag          = cpu_addr[AW+1:INDEX_BITS+2];
  assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

  // The outstanding request's line is recovered from the held memory address.
  assign fill_index = mem_addr[INDEX_BITS-1:0];
  assign fill_tag   = mem_addr[AW-1:INDEX_BITS];

  assign hit       = valid[req_index] && (tags[req_index] == req_tag);
  assign cpu_ready = (state == IDLE);
  assign fsm_state = state;

  always_comb begin
    state_next  = state;
    load_hit    = 1'b0;
    issue_fill  = 1'b0;
    issue_write = 1'b0;
    complete    = 1'b0;
    fill_done   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            issue_write = 1'b1;
            state_next  = WRITE;
          end else if (hit) begin
            load_hit = 1'b1;
          end else begin
            issue_fill = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (mem_ack) begin
          complete   = 1'b1;
          fill_done  = 1'b1;
          state_next = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      cpu_resp  <= 1'b0;
      cpu_rdata <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      state    <= state_next;
      cpu_resp <= load_hit || complete;
      if (load_hit) begin
        cpu_rdata <= data[req_index];
      end
      if (issue_fill || issue_write) begin
        mem_req  <= 1'b1;
        mem_we   <= issue_write;
        mem_addr <= cpu_addr[AW+1:2];
        if (issue_write) begin
          mem_wdata <= cpu_wdata;
        end
      end
      if (complete) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      if (fill_done) begin
        valid[fill_index] <= 1'b1;
        cpu_rdata         <= mem_rdata;
      end
    end
  end

  // Tag/data storage carries no reset; a store miss leaves the line untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_done) begin
        tags[fill_index] <= fill_tag;
        data[fill_index] <= mem_rdata;
      end else if (issue_write && hit) begin
        data[req_index] <= cpu_wdata;
      end
    end
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter INDEX_BITS, default 4, line-index width; the cache holds 2^INDEX_BITS lines of one 32-bit word each.
REQ-002 Parameter TAG_BITS, default 8, tag width; the word-address width is AW = INDEX_BITS+TAG_BITS (default 12).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 cpu_req  input  1  CPU access request; accepted on a clk edge where cpu_req=1 and cpu_ready=1.
REQ-007 cpu_we  input  1  1=store, 0=load; sampled on acceptance.
REQ-008 cpu_addr  input  32  byte address; bits [1:0] and bits above AW+1 are ignored.
REQ-009 cpu_wdata  input  32  store data; sampled on acceptance.
REQ-010 cpu_ready  output  1  the block can accept a request this cycle.
REQ-011 cpu_resp  output  1  one-cycle pulse; the access has completed.
REQ-012 cpu_rdata  output  32  load data; valid while cpu_resp=1 for a load.
REQ-013 mem_req  output  1  backing-memory request; held until mem_ack.
REQ-014 mem_we  output  1  backing-memory write strobe; qualified by mem_req.
REQ-015 mem_addr  output  AW  backing-memory word address (cpu_addr[AW+1:2]).
REQ-016 mem_wdata  output  32  backing-memory write data.
REQ-017 mem_ack  input  1  backing memory completes the current request; variable latency of at least 1 cycle.
REQ-018 mem_rdata  input  32  read data; valid when mem_ack=1 and mem_we=0.

Function
REQ-019 Addressing: index = cpu_addr[INDEX_BITS+1:2]; tag = cpu_addr[AW+1:INDEX_BITS+2]; each line stores valid, tag and data.
REQ-020 A hit SHALL be defined as: the indexed line is valid and its stored tag equals the request tag.
REQ-021 FSM states: IDLE, FILL, WRITE; cpu_ready = 1 exactly when the state is IDLE.
REQ-022 IDLE, load hit accepted at edge N: cpu_resp=1 with the line data in cycle N+1; the state stays IDLE; back-to-back hits complete at one per cycle.
REQ-023 IDLE, load miss accepted at edge N: enter FILL; mem_req=1, mem_we=0, mem_addr set to the request word address from cycle N+1.
REQ-024 FILL, mem_ack at edge M: write the line (valid=1, tag, data=mem_rdata); set cpu_rdata=mem_rdata; cpu_resp=1, mem_req=0 and state IDLE from cycle M+1.
REQ-025 IDLE, store accepted at edge N: enter WRITE; mem_req=1, mem_we=1, mem_addr and mem_wdata set to the request from cycle N+1; the store is write-through.
REQ-026 Store hit: the line data SHALL be updated at acceptance, so a load to the same address in the cycle after cpu_resp returns the new data.
REQ-027 Store miss: no allocation; the line is unchanged.
REQ-028 WRITE, mem_ack at edge M: cpu_resp=1, mem_req=0, mem_we=0 and state IDLE from cycle M+1; cpu_rdata holds its previous value.
REQ-029 mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable from assertion until the mem_ack edge.
REQ-030 mem_ack SHALL be ignored in IDLE.
REQ-031 cpu_req SHALL be ignored while cpu_ready=0; no request is queued.
REQ-032 cpu_resp SHALL be 1 for exactly one cycle per accepted request, and responses return in acceptance order.

Reset
REQ-033 When rst=1 at a clk edge: state=IDLE, all valid bits=0, cpu_resp=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; cpu_ready=1 from the next cycle.
REQ-034 Reset in FILL or WRITE SHALL abandon the transaction without issuing cpu_resp; no line is written; mem_req drops in the next cycle.
REQ-035 Tag and data arrays need not be reset.

Verification
REQ-036 Cold load to 0x40, mem_ack 3 cycles after mem_req -> mem_addr=0x010, mem_we=0; one cpu_resp pulse with the mem_rdata value; ready only in IDLE.
REQ-037 Repeat the load to 0x40 -> cpu_resp in the next cycle with the same data; mem_req stays 0.
REQ-038 Store 0xDEADBEEF to 0x40 (hit), then load 0x40 -> mem_we=1, mem_wdata=0xDEADBEEF until ack; the load hits and returns 0xDEADBEEF.
REQ-039 Load 0x440 (same index as 0x40, different tag) -> miss, FILL at mem_addr=0x110; the line is replaced; a following load of 0x40 misses.
REQ-040 Store miss to 0x80, then load 0x80 -> the store does not allocate; the load issues a FILL.
REQ-041 rst asserted during a FILL with mem_ack pending -> no cpu_resp; mem_req=0 next cycle; a subsequent load to the same address misses.
